rr_vn_p_sched: RTL and testbench



---
 rtl/rr_vn_p_sched_pkg.sv | 16 +
 rtl/rr_vn_p_sched_quota_ctrl.sv | 48 ++++
 rtl/rr_vn_p_sched.sv | 83 ++++++++
 tb/tb_rr_vn_p_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_vn_p_sched_pkg.sv
// rr_vn_p_sched_pkg: shared Log2 helper, default-size localparams and FSM state encodings
package rr_vn_p_sched_pkg;
  function automatic int Log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  localparam int NUM_VC_DEF = 1;
  localparam int NUM_VN_DEF = 3;
  localparam int bits_VN = Log2(NUM_VN_DEF);
  localparam int bits_VC = Log2(NUM_VC_DEF);
  localparam int NUM_VN_X_VC = NUM_VN_DEF * NUM_VC_DEF;
  localparam int bits_VN_X_VC = Log2(NUM_VN_X_VC);
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;
endpackage

// File: rtl/rr_vn_p_sched_quota_ctrl.sv
// rr_vn_p_quota_ctrl: per-VN quota config regs, live quota counter and priority-VN rotation (upd = ack of granted g_vn; prio_nxt = post-update prio)
module rr_vn_p_quota_ctrl import rr_vn_p_sched_pkg::*; #(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  parameter int QUOTA_W = 4,
  parameter int DEFAULT_QUOTA = 4
) (
  input  logic clk,
  input  logic rst_p,
  input  logic [NUM_VN*NUM_VC-1:0] req,
  input  logic [NUM_VN*QUOTA_W-1:0] quota_cfg,
  input  logic cfg_load,
  input  logic upd,
  input  logic [Log2(NUM_VN)-1:0] g_vn,
  output logic [Log2(NUM_VN)-1:0] prio_vn,
  output logic [Log2(NUM_VN)-1:0] prio_nxt
);
  localparam int VW = Log2(NUM_VN);
  logic [NUM_VN-1:0][QUOTA_W-1:0] cfg_q, cfg_d;
  logic [QUOTA_W-1:0] cnt_q, cnt_d, cnt_dec, reload;
  logic [VW-1:0] prio_q, prio_d, prio_inc;
  logic [NUM_VC-1:0] prio_req;
  logic adv;
  always_comb begin
    cnt_dec = (g_vn == prio_q) ? cnt_q - 1'b1 : cnt_q;
    prio_req = req[prio_q*NUM_VC +: NUM_VC];
    adv = (cnt_dec == '0) || (prio_req == '0);
    prio_inc = (prio_q == VW'(NUM_VN - 1)) ? '0 : prio_q + 1'b1;
    // reload reads cfg_q, so a same-cycle cfg_load does not affect it
    reload = (cfg_q[prio_inc] == '0) ? QUOTA_W'(1) : cfg_q[prio_inc];
    prio_d = (upd && adv) ? prio_inc : prio_q;
    cnt_d = !upd ? cnt_q : (adv ? reload : cnt_dec);
    cfg_d = cfg_load ? quota_cfg : cfg_q;
  end
  always_ff @(posedge clk) begin
    if (rst_p) begin
      cfg_q <= {NUM_VN{QUOTA_W'(DEFAULT_QUOTA)}};
      cnt_q <= QUOTA_W'(DEFAULT_QUOTA);
      prio_q <= '0;
    end else begin
      cfg_q <= cfg_d;
      cnt_q <= cnt_d;
      prio_q <= prio_d;
    end
  end
  assign prio_vn = prio_q;
  assign prio_nxt = prio_d;
endmodule

// File: rtl/rr_vn_p_sched.sv
// rr_vn_p_sched: weighted round-robin VN x VC scheduler, held one-hot grant with valid/ack (req, quota_cfg, cfg_load, grant_ack -> grant, grant_valid, prio_vn, token; grant_cnt when RR_VN_P_SCHED_STATS_EN)
module rr_vn_p_sched import rr_vn_p_sched_pkg::*; #(
  parameter int NUM_VC = 1,
  parameter int NUM_VN = 3,
  parameter int QUOTA_W = 4,
  parameter int DEFAULT_QUOTA = 4
) (
  input  logic clk,
  input  logic rst_p,
  input  logic [NUM_VN*NUM_VC-1:0] req,
  input  logic [NUM_VN*QUOTA_W-1:0] quota_cfg,
  input  logic cfg_load,
  input  logic grant_ack,
  output logic [NUM_VN*NUM_VC-1:0] grant,
  output logic grant_valid,
  output logic [Log2(NUM_VN)-1:0] prio_vn,
`ifdef RR_VN_P_SCHED_STATS_EN
  output logic [NUM_VN*16-1:0] grant_cnt,
`endif
  output logic [Log2(NUM_VN*NUM_VC)-1:0] token
);
  localparam int N = NUM_VN * NUM_VC;
  localparam int VW = Log2(NUM_VN);
  localparam int TW = Log2(N);
  state_t state_q, state_d;
  logic [N-1:0] grant_q, grant_d, pick;
  logic [TW-1:0] token_q, token_d;
  logic [VW-1:0] g_vn, prio_nxt;
  logic found, upd;
  int g_idx, g_vc;
  always_comb begin
    g_idx = 0;
    for (int i = 0; i < N; i++) if (grant_q[i]) g_idx = i;
    g_vn = VW'(g_idx / NUM_VC);
    g_vc = g_idx % NUM_VC;
    upd = (state_q == S_GRANT) && grant_ack;
  end
  // first request at or above token, wrapping past the top index
  always_comb begin
    pick = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(token_q) + i) % N]) begin
        pick[(int'(token_q) + i) % N] = 1'b1;
        found = 1'b1;
      end
    end
    state_d = (state_q == S_IDLE) ? (found ? S_GRANT : S_IDLE) : (grant_ack ? S_IDLE : S_GRANT);
    grant_d = (state_q == S_IDLE) ? pick : (grant_ack ? '0 : grant_q);
  end
  always_comb begin
    token_d = upd ? TW'((int'(prio_nxt) * NUM_VC + ((g_vn == prio_nxt) ? g_vc + 1 : 0)) % N) : token_q;
  end
  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      token_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      token_q <= token_d;
    end
  end
  rr_vn_p_quota_ctrl #(
    .NUM_VC(NUM_VC), .NUM_VN(NUM_VN), .QUOTA_W(QUOTA_W), .DEFAULT_QUOTA(DEFAULT_QUOTA)
  ) u_quota (
    .clk(clk), .rst_p(rst_p), .req(req), .quota_cfg(quota_cfg), .cfg_load(cfg_load),
    .upd(upd), .g_vn(g_vn), .prio_vn(prio_vn), .prio_nxt(prio_nxt)
  );
`ifdef RR_VN_P_SCHED_STATS_EN
  logic [NUM_VN-1:0][15:0] stat_q, stat_d;
  always_comb begin
    stat_d = stat_q;
    if (upd && stat_q[g_vn] != 16'hFFFF) stat_d[g_vn] = stat_q[g_vn] + 16'd1;
  end
  always_ff @(posedge clk) stat_q <= rst_p ? '0 : stat_d;
  assign grant_cnt = stat_q;
`endif
  assign grant = grant_q;
  assign grant_valid = (state_q == S_GRANT);
  assign token = token_q;
endmodule

// File: tb/tb_rr_vn_p_sched.sv
// tb_rr_vn_p_sched: scoreboard bench for rr_vn_p_sched with NUM_VC=2, NUM_VN=3, DEFAULT_QUOTA=2
module tb_rr_vn_p_sched;
  typedef struct packed {
    logic [5:0] g;
    logic [1:0] p;
    logic [2:0] t;
  } exp_t;
  logic clk = 1'b0;
  logic rst_p, cfg_load, grant_ack, grant_valid;
  logic [5:0] req, grant;
  logic [11:0] quota_cfg;
  logic [1:0] prio_vn;
  logic [2:0] token;
`ifdef RR_VN_P_SCHED_STATS_EN
  logic [47:0] grant_cnt;
`endif
  exp_t exp_q[$];
  exp_t e;
  int tests = 0, fails = 0;
  logic prev_v = 1'b0;
  always #5 clk = ~clk;
  rr_vn_p_sched #(.NUM_VC(2), .NUM_VN(3), .QUOTA_W(4), .DEFAULT_QUOTA(2)) dut (
    .clk(clk), .rst_p(rst_p), .req(req), .quota_cfg(quota_cfg), .cfg_load(cfg_load),
    .grant_ack(grant_ack), .grant(grant), .grant_valid(grant_valid), .prio_vn(prio_vn),
`ifdef RR_VN_P_SCHED_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .token(token)
  );
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input int b, input int p, input int t);
    exp_t x;
    x.g = 6'(1 << b);
    x.p = 2'(p);
    x.t = 3'(t);
    exp_q.push_back(x);
  endtask
  task automatic wait_valid();
    int n = 0;
    while (!grant_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!grant_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: got no grant_valid expected grant within 20 cycles");
    end
  endtask
  task automatic do_ack();
    wait_valid();
    grant_ack = 1'b1;
    @(posedge clk); #1;
    grant_ack = 1'b0;
  endtask
  task automatic reset_dut();
    rst_p = 1'b1;
    req = '0;
    grant_ack = 1'b0;
    cfg_load = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_p = 1'b0;
  endtask
  always @(negedge clk) begin
    if (grant_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got grant %0h expected no grant", grant);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant", grant, e.g);
        check("sb_prio", prio_vn, e.p);
        check("sb_token", token, e.t);
      end
    end
    prev_v = grant_valid;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_p = 1'b1; req = 6'h3F; grant_ack = 1'b0; cfg_load = 1'b0; quota_cfg = '0;
    repeat (2) begin
      @(negedge clk);
      check("t1_rst_grant", grant, 0);
      check("t1_rst_valid", grant_valid, 0);
      check("t1_rst_prio", prio_vn, 0);
      check("t1_rst_token", token, 0);
    end
    rst_p = 1'b0;
    push(0, 0, 0);
    @(negedge clk);
    check("t1_valid", grant_valid, 1);
    push(1, 0, 1); push(2, 1, 2); push(3, 1, 3); push(4, 2, 4); push(5, 2, 5); push(0, 0, 0);
    repeat (7) do_ack();
    req = '0;
    check("t2_token", token, 1);
    check("t2_prio", prio_vn, 0);
    reset_dut();
    req = 6'b010000;
    push(4, 0, 0);
    do_ack();
    req = '0;
    check("t3_prio", prio_vn, 1);
    check("t3_token", token, 2);
    reset_dut();
    req = 6'h01;
    push(0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req = (i % 2 == 0) ? 6'h3E : 6'h01;
      @(negedge clk);
      check("t4_hold_grant", grant, 6'b000001);
      check("t4_hold_valid", grant_valid, 1);
      @(posedge clk); #1;
    end
    grant_ack = 1'b1;
    @(posedge clk); #1;
    grant_ack = 1'b0;
    req = '0;
    check("t4_valid_drop", grant_valid, 0);
    check("t4_grant_drop", grant, 0);
    reset_dut();
    req = 6'h3F;
    push(0, 0, 0); push(1, 0, 1); push(2, 1, 2); push(3, 1, 3); push(4, 2, 4); push(0, 0, 0);
    push(2, 1, 2); push(3, 1, 3); push(4, 1, 4); push(2, 1, 2); push(4, 2, 4);
    do_ack();
    wait_valid();
    grant_ack = 1'b1;
    cfg_load = 1'b1;
    quota_cfg = {4'd1, 4'd3, 4'd0};
    @(posedge clk); #1;
    grant_ack = 1'b0;
    cfg_load = 1'b0;
    check("t5_adv_prio", prio_vn, 1);
    check("t5_adv_token", token, 2);
    repeat (9) do_ack();
    req = '0;
    check("t5_end_prio", prio_vn, 0);
    check("t5_end_token", token, 0);
    reset_dut();
    req = 6'h3F;
    push(0, 0, 0);
    do_ack();
    push(1, 0, 1);
    wait_valid();
    rst_p = 1'b1;
    grant_ack = 1'b1;
    @(posedge clk); #1;
    grant_ack = 1'b0;
    check("t6_grant", grant, 0);
    check("t6_valid", grant_valid, 0);
    check("t6_prio", prio_vn, 0);
    check("t6_token", token, 0);
`ifdef RR_VN_P_SCHED_STATS_EN
    check("t6_stats_clr", grant_cnt, 0);
`endif
    @(posedge clk); #1;
    rst_p = 1'b0;
    push(0, 0, 0);
    do_ack();
    req = '0;
    check("t6_post_token", token, 1);
`ifdef RR_VN_P_SCHED_STATS_EN
    check("t6_stats_cnt", grant_cnt, 48'h1);
`endif
    repeat (4) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
